rt_quad_dec: RTL and testbench
==============================

RT_QUAD_DEC -- requirements
Module: rt_quad_dec

Interface
REQ-001 Parameter PARAM_FILT_LEN, default 4: number of consecutive stable cycles required before a filtered input is accepted (range 2..16).
REQ-002 Parameter PARAM_ERR_BIT_NUM, default 8: width of the error counter.
REQ-003 rt_i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 rt_i_rst_n  input  1  asynchronous active-low reset.
REQ-005 rt_i_a  input  1  quadrature phase A, asynchronous to rt_i_clk.
REQ-006 rt_i_b  input  1  quadrature phase B, asynchronous to rt_i_clk.
REQ-007 rt_i_z  input  1  index pulse, asynchronous to rt_i_clk.
REQ-008 rt_i_en  input  1  decode enable; when low, the decoder tracks phase state but suppresses rt_o_ce and rt_o_err.
REQ-009 rt_i_clr_err  input  1  synchronous clear of rt_o_err_cnt.
REQ-010 rt_o_ce  output  1  one-cycle count-enable pulse per valid quadrature step; connects directly to rt_bin_cnt rt_i_ce.
REQ-011 rt_o_inc_n  output  1  step direction (0: forward, 1: reverse); valid while rt_o_ce=1; connects to rt_bin_cnt rt_i_inc_n.
REQ-012 rt_o_idx  output  1  one-cycle pulse on each accepted rising edge of Z.
REQ-013 rt_o_err  output  1  one-cycle pulse on an illegal (double) phase transition.
REQ-014 rt_o_err_cnt  output  PARAM_ERR_BIT_NUM  saturating count of illegal transitions.

Function
REQ-015 A, B and Z shall each pass through a two-flop synchronizer before any other use.
REQ-016 The decoder shall hold a 2-bit phase state {A,B} with Gray order 00->01->11->10->00 defined as forward.
REQ-017 A single-bit change in forward order shall produce rt_o_ce=1 and rt_o_inc_n=0 for exactly one cycle.
REQ-018 A single-bit change in reverse order shall produce rt_o_ce=1 and rt_o_inc_n=1 for exactly one cycle.
REQ-019 A simultaneous two-bit change shall produce rt_o_err=1 for one cycle and rt_o_ce=0, and the phase state shall take the new value.
REQ-020 No change shall produce rt_o_ce=0 and rt_o_err=0.
REQ-021 Latency without filter: an input change shall be reflected on rt_o_ce three rising edges after the change (2 synchronizer edges plus 1 decode edge).
REQ-022 rt_o_err_cnt shall increment on each rt_o_err pulse and saturate at all-ones; rt_i_clr_err=1 shall load 0 and takes priority over a same-cycle increment.
REQ-023 With rt_i_en=0, the phase state and Z edge detection shall keep tracking; rt_o_ce, rt_o_err and rt_o_idx shall be 0, and rt_o_err_cnt shall not change.
REQ-024 The first synchronized (and filtered, if compiled in) sample after reset shall load the phase state without producing rt_o_ce or rt_o_err.

Reset
REQ-025 Asserting rt_i_rst_n=0 shall immediately clear synchronizers, filters, phase state, the init flag, and all outputs; rt_o_inc_n resets to 0 and rt_o_err_cnt resets to 0.
REQ-026 A reset asserted mid-step shall discard any pending step; no pulse shall be emitted after reset release until REQ-024 initialization completes.

Configuration
REQ-027 Macro RT_QUAD_DEC_FILTER_EN defined: each synchronized input shall be accepted only after it holds a new value for PARAM_FILT_LEN consecutive cycles, adding PARAM_FILT_LEN cycles of latency; shorter glitches shall be ignored.
REQ-028 Macro RT_QUAD_DEC_FILTER_EN undefined: synchronizer outputs shall feed the decoder directly, and PARAM_FILT_LEN shall be unused.

Structure
REQ-029 The shared package rt_pkg shall hold the 2-bit phase-state encoding constants and the forward-step lookup used by the decoder.
REQ-030 The glitch filter shall be a sub-module rt_glitch_filt, instantiated three times (A, B, Z) only when RT_QUAD_DEC_FILTER_EN is defined.

Verification
REQ-031 Filter off, AB stepped 00->01->11->10->00, 8 cycles per step -> 4 ce pulses with inc_n=0, each 3 edges after its change.
REQ-032 Filter off, AB stepped 00->10->11->01->00 -> 4 ce pulses with inc_n=1; rt_bin_cnt loaded with 4 reads 0 afterward.
REQ-033 AB jumps 00->11 -> rt_o_err=1 for one cycle, ce=0, err_cnt=1; 300 jumps with PARAM_ERR_BIT_NUM=8 -> err_cnt=255; clr_err -> 0.
REQ-034 Filter on, PARAM_FILT_LEN=4, 2-cycle glitch on A -> no ce; 4-cycle step -> one ce at 3+4 edges after the change.
REQ-035 rt_i_en=0 during 3 forward steps, then rt_i_en=1 and 1 forward step -> exactly one ce; Z rising edge with en=1 -> rt_o_idx one cycle.
REQ-036 rt_i_rst_n pulsed low 1 cycle after an A change -> no ce; first post-reset sample initializes state with no pulse.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared quadrature definitions: Gray-coded phase states, the forward-step
// lookup and the step classifier used by rt_quad_dec.
package rt_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] ph);
        case (ph)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

    function automatic step_t classify(input logic [1:0] old_ph, input logic [1:0] new_ph);
        if (new_ph == old_ph)
            return STEP_NONE;
        else if (new_ph == fwd_next(old_ph))
            return STEP_FWD;
        else if (old_ph == fwd_next(new_ph))
            return STEP_REV;
        else
            return STEP_ERR;
    endfunction

endpackage

// File: rtl/rt_glitch_filt.sv
// Per-input glitch filter: a new level is accepted only after it has been
// stable for PARAM_FILT_LEN consecutive cycles; o_vld marks the first acceptance.
module rt_glitch_filt #(
    parameter int PARAM_FILT_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vld,
    input  logic i_d,
    output logic o_d,
    output logic o_vld
);

    localparam int CW = (PARAM_FILT_LEN > 2) ? $clog2(PARAM_FILT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(PARAM_FILT_LEN - 1);

    logic          r_d;
    logic          r_vld;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d   <= 1'b0;
            r_vld <= 1'b0;
            r_cnt <= '0;
        end else if (i_vld) begin
            if (!r_vld) begin
                // Before the first acceptance, require the raw level to be stable.
                r_d <= i_d;
                if (i_d != r_d)
                    r_cnt <= '0;
                else if (r_cnt == LAST) begin
                    r_vld <= 1'b1;
                    r_cnt <= '0;
                end else
                    r_cnt <= r_cnt + 1'b1;
            end else if (i_d == r_d) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_d   <= i_d;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_d   = r_d;
    assign o_vld = r_vld;

endmodule

// File: rtl/rt_quad_dec.sv
// Quadrature decoder: synchronizes A/B/Z, decodes Gray steps into ce/inc_n
// pulses, flags double transitions. Define RT_QUAD_DEC_FILTER_EN to add glitch filters.
module rt_quad_dec
    import rt_pkg::*;
#(
    parameter int PARAM_FILT_LEN    = 4,
    parameter int PARAM_ERR_BIT_NUM = 8
) (
    input  logic                         rt_i_clk,
    input  logic                         rt_i_rst_n,
    input  logic                         rt_i_a,
    input  logic                         rt_i_b,
    input  logic                         rt_i_z,
    input  logic                         rt_i_en,
    input  logic                         rt_i_clr_err,
    output logic                         rt_o_ce,
    output logic                         rt_o_inc_n,
    output logic                         rt_o_idx,
    output logic                         rt_o_err,
    output logic [PARAM_ERR_BIT_NUM-1:0] rt_o_err_cnt
);

    // Bit order everywhere below: {z, a, b}.
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [1:0] r_sync_vld;
    logic [2:0] w_smp;
    logic       w_smp_vld;

    always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
        if (!rt_i_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync1    <= {rt_i_z, rt_i_a, rt_i_b};
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

`ifdef RT_QUAD_DEC_FILTER_EN
    logic [2:0] w_filt_vld;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_filt
            rt_glitch_filt #(
                .PARAM_FILT_LEN (PARAM_FILT_LEN)
            ) u_filt (
                .i_clk   (rt_i_clk),
                .i_rst_n (rt_i_rst_n),
                .i_vld   (r_sync_vld[1]),
                .i_d     (r_sync2[gi]),
                .o_d     (w_smp[gi]),
                .o_vld   (w_filt_vld[gi])
            );
        end
    endgenerate

    assign w_smp_vld = &w_filt_vld;
`else
    assign w_smp     = r_sync2;
    assign w_smp_vld = r_sync_vld[1];
`endif

    logic [1:0]                   r_phase;
    logic                         r_init;
    logic                         r_z_prev;
    logic                         r_ce;
    logic                         r_inc_n;
    logic                         r_err;
    logic                         r_idx;
    logic [PARAM_ERR_BIT_NUM-1:0] r_err_cnt;
    step_t                        w_step;
    logic                         w_z_rise;
    logic                         w_move;

    // Nothing is decoded until the first valid sample has loaded the state.
    always_comb begin
        w_step   = STEP_NONE;
        w_z_rise = 1'b0;
        if (w_smp_vld && r_init) begin
            w_step   = classify(r_phase, w_smp[1:0]);
            w_z_rise = w_smp[2] & ~r_z_prev;
        end
    end

    assign w_move = (w_step == STEP_FWD) || (w_step == STEP_REV);

    always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
        if (!rt_i_rst_n) begin
            r_phase   <= PH_00;
            r_init    <= 1'b0;
            r_z_prev  <= 1'b0;
            r_ce      <= 1'b0;
            r_inc_n   <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_smp_vld) begin
                r_phase  <= w_smp[1:0];
                r_z_prev <= w_smp[2];
                r_init   <= 1'b1;
            end
            r_ce  <= rt_i_en && w_move;
            r_err <= rt_i_en && (w_step == STEP_ERR);
            r_idx <= rt_i_en && w_z_rise;
            if (w_move)
                r_inc_n <= (w_step == STEP_REV);
            if (rt_i_clr_err)
                r_err_cnt <= '0;
            else if (rt_i_en && (w_step == STEP_ERR) && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign rt_o_ce      = r_ce;
    assign rt_o_inc_n   = r_inc_n;
    assign rt_o_idx     = r_idx;
    assign rt_o_err     = r_err;
    assign rt_o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_rt_quad_dec.sv
// Self-checking bench for rt_quad_dec: vector table plus hand-written corner
// sequences; every expected pulse is queued with its due cycle and matched on arrival.
module tb_rt_quad_dec;

    localparam int FL = 4;
    localparam int EW = 8;
`ifdef RT_QUAD_DEC_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a = 1'b0, b = 1'b0, z = 1'b0, en = 1'b1, clr = 1'b0;
    logic          ce, inc_n, idx, err;
    logic [EW-1:0] err_cnt;

    rt_quad_dec #(
        .PARAM_FILT_LEN    (FL),
        .PARAM_ERR_BIT_NUM (EW)
    ) dut (
        .rt_i_clk     (clk),
        .rt_i_rst_n   (rst_n),
        .rt_i_a       (a),
        .rt_i_b       (b),
        .rt_i_z       (z),
        .rt_i_en      (en),
        .rt_i_clr_err (clr),
        .rt_o_ce      (ce),
        .rt_o_inc_n   (inc_n),
        .rt_o_idx     (idx),
        .rt_o_err     (err),
        .rt_o_err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic ce;
        logic inc_n;
        logic err;
        logic idx;
        int   due;
    } exp_t;

    // {a, b, z, en, exp ce, exp inc_n, exp err, exp idx}
    typedef struct packed {
        logic a;
        logic b;
        logic z;
        logic en;
        logic ce;
        logic inc_n;
        logic err;
        logic idx;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   bin_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input logic c, input logic i, input logic e, input logic x);
        exp_t t;
        t.ce    = c;
        t.inc_n = c ? i : 1'b0;
        t.err   = e;
        t.idx   = x;
        t.due   = cyc + LAT;
        q.push_back(t);
    endtask

    task automatic monitor();
        exp_t e;
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_pulse actual=none required=pulse at cycle %0d", e.due);
        end
        if (ce | err | idx) begin
            if (ce) bin_cnt += inc_n ? -1 : 1;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=ce%0b inc_n%0b err%0b idx%0b required=none (cycle %0d)",
                         ce, inc_n, err, idx, cyc);
            end else begin
                e = q.pop_front();
                $display("pulse cycle=%0d ce=%0b inc_n=%0b err=%0b idx=%0b err_cnt=%0d",
                         cyc, ce, inc_n, err, idx, err_cnt);
                chk("pulse_cycle", cyc, e.due);
                chk("pulse_bits", int'({ce, ce & inc_n, err, idx}),
                    int'({e.ce, e.inc_n, e.err, e.idx}));
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
        end
    endtask

    initial begin
        vec_t vt[18];
        int   exp_errs;

        vt[0]  = 8'b01_0_1_1000;
        vt[1]  = 8'b11_0_1_1000;
        vt[2]  = 8'b10_0_1_1000;
        vt[3]  = 8'b00_0_1_1000;
        vt[4]  = 8'b10_0_1_1100;
        vt[5]  = 8'b11_0_1_1100;
        vt[6]  = 8'b01_0_1_1100;
        vt[7]  = 8'b00_0_1_1100;
        vt[8]  = 8'b11_0_1_0010;
        vt[9]  = 8'b00_0_1_0010;
        vt[10] = 8'b00_1_1_0001;
        vt[11] = 8'b00_0_1_0000;
        vt[12] = 8'b01_0_0_0000;
        vt[13] = 8'b11_0_0_0000;
        vt[14] = 8'b10_0_0_0000;
        vt[15] = 8'b00_0_1_1000;
        vt[16] = 8'b00_1_0_0000;
        vt[17] = 8'b00_0_1_0000;

        tick(3);
        chk("reset_outputs", int'({ce, inc_n, err, idx}), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        tick(20);

        exp_errs = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 4) bin_cnt = 4;
            a  = vt[i].a;
            b  = vt[i].b;
            z  = vt[i].z;
            en = vt[i].en;
            if (vt[i].ce | vt[i].err | vt[i].idx)
                expect_pulse(vt[i].ce, vt[i].inc_n, vt[i].err, vt[i].idx);
            if (vt[i].err && exp_errs < 255) exp_errs++;
            tick(10);
            if (i == 7) chk("bin_cnt_after_reverse", bin_cnt, 0);
        end
        chk("err_cnt_after_table", int'(err_cnt), exp_errs);

        for (int k = 0; k < 300; k++) begin
            {a, b} = (k % 2 == 0) ? 2'b11 : 2'b00;
            expect_pulse(1'b0, 1'b0, 1'b1, 1'b0);
            if (exp_errs < 255) exp_errs++;
            tick(10);
        end
        chk("err_cnt_saturated", int'(err_cnt), exp_errs);

        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("err_cnt_cleared", int'(err_cnt), 0);

        // Clear lands on the same edge as an error increment.
        {a, b} = 2'b11;
        expect_pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick(LAT - 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_priority", int'(err_cnt), 0);
        tick(9);
        {a, b} = 2'b00;
        expect_pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick(10);
        chk("err_cnt_one", int'(err_cnt), 1);

        {a, b} = 2'b10;
        expect_pulse(1'b1, 1'b1, 1'b0, 1'b0);
        tick(10);

        // Reset one cycle after an A change: the step must be dropped.
        a = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("midstep_reset_outputs", int'({ce, inc_n, err, idx}), 0);
        chk("midstep_reset_err_cnt", int'(err_cnt), 0);
        tick(1);
        rst_n = 1'b1;
        tick(24);
        {a, b} = 2'b01;
        expect_pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick(10);

`ifdef RT_QUAD_DEC_FILTER_EN
        a = 1'b1;
        tick(2);
        a = 1'b0;
        tick(14);
        a = 1'b1;
        expect_pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick(12);
`endif

        tick(LAT + 2);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
